// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single memory bus (ROM 0x0000-0x1FFF, RAM 0x2000-0x2FFF) between the
//   instruction-fetch port (i_*) and the load/store port (d_*). One access at a time,
//   per-region wait states, registered read data with a one-cycle ready pulse, and
//   illegal accesses (unmapped address, store to ROM) flagged without touching the bus.
//
// Parameters
//   ROM_WAIT  extra ACCESS cycles for ROM (0..15)
//   RAM_WAIT  extra ACCESS cycles for RAM (0..15)
//
// Configuration macro
//   MEM_ARB_RR_EN  defined: round-robin between ports; undefined: data port has priority.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_req/i_addr -> i_ready/i_fault/i_rdata                  fetch port
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_fault/d_rdata     load/store port
//   bus_addr/bus_we/bus_wdata -> memories, bus_rdata <- memories
//   busy                               high whenever an access is in progress
module mem_bus_arbiter #(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_fault,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_fault,
  output logic [31:0] d_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  ACCESS    = 2'd1;
  localparam logic [1:0]  RESP      = 2'd2;
  localparam logic        OWN_FETCH = 1'b0;
  localparam logic        OWN_DATA  = 1'b1;
  localparam logic [31:0] RAM_BASE  = 32'h0000_2000;
  localparam logic [31:0] RAM_END   = 32'h0000_3000;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_grant;
  logic        fault_r;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;

  logic        grant_d;
  logic        grant_i;
  logic        grant_any;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        sel_rom;
  logic        sel_ram;
  logic        sel_illegal;
  logic        next_last_grant;

  // Arbitration and address classification (evaluated every cycle, used in IDLE)
  always_comb begin
`ifdef MEM_ARB_RR_EN
    // Contention goes to whichever port was not served last.
    grant_d = d_req && (!i_req || (last_grant == OWN_FETCH));
`else
    grant_d = d_req;
`endif
    grant_i     = i_req && !grant_d;
    grant_any   = grant_d || grant_i;
    sel_addr    = grant_d ? d_addr : i_addr;
    sel_wdata   = grant_d ? d_wdata : 32'h0;
    sel_we      = grant_d && d_we;
    sel_rom     = (sel_addr < RAM_BASE);
    sel_ram     = !sel_rom && (sel_addr < RAM_END);
    sel_illegal = !(sel_rom || sel_ram) || (sel_we && sel_rom);
    next_last_grant = (state == IDLE && grant_any) ? (grant_d ? OWN_DATA : OWN_FETCH)
                                                    : last_grant;
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= OWN_FETCH;
      last_grant <= OWN_FETCH;
      fault_r    <= 1'b0;
      i_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      last_grant <= next_last_grant;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner   <= grant_d ? OWN_DATA : OWN_FETCH;
            fault_r <= sel_illegal;
            if (sel_illegal) begin
              // Illegal accesses skip the bus entirely and answer with zero data.
              state <= RESP;
              if (grant_d) d_rdata <= 32'h0;
              else         i_rdata <= 32'h0;
            end else begin
              state <= ACCESS;
              cnt   <= sel_rom ? 4'(ROM_WAIT) : 4'(RAM_WAIT);
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            if (!lat_we) begin
              if (owner == OWN_DATA) d_rdata <= bus_rdata;
              else                   i_rdata <= bus_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload, captured at grant; only observed while ACCESS
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_any) begin
      lat_addr  <= sel_addr;
      lat_we    <= sel_we;
      lat_wdata <= sel_wdata;
    end
  end

  // Outputs decode straight from state so reset clears them immediately
  assign busy      = (state != IDLE);
  assign bus_addr  = (state == ACCESS) ? lat_addr : 32'h0;
  assign bus_we    = (state == ACCESS) && (cnt == 4'd0) && lat_we;
  assign bus_wdata = ((state == ACCESS) && lat_we) ? lat_wdata : 32'h0;
  assign i_ready   = (state == RESP) && (owner == OWN_FETCH);
  assign d_ready   = (state == RESP) && (owner == OWN_DATA);
  assign i_fault   = i_ready && fault_r;
  assign d_fault   = d_ready && fault_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_fault;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_fault;
  logic [31:0] d_rdata;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(.ROM_WAIT(2), .RAM_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_fault(i_fault), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_fault(d_fault), .d_rdata(d_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_ready"},   32'(i_ready),   32'h0);
    chk({tag, "_i_fault"},   32'(i_fault),   32'h0);
    chk({tag, "_i_rdata"},   i_rdata,        32'h0);
    chk({tag, "_d_ready"},   32'(d_ready),   32'h0);
    chk({tag, "_d_fault"},   32'(d_fault),   32'h0);
    chk({tag, "_d_rdata"},   d_rdata,        32'h0);
    chk({tag, "_bus_addr"},  bus_addr,       32'h0);
    chk({tag, "_bus_we"},    32'(bus_we),    32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata,      32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    logic [31:0] got [4];
    logic [31:0] exp_seq [4];

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; bus_rdata = '0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_bus_addr", bus_addr, 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Load from RAM: ready in 3rd cycle after grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004; bus_rdata = 32'hDEADBEEF;
    tick();
    chk("ld_c1_busy", 32'(busy), 32'h1);
    chk("ld_c1_bus_addr", bus_addr, 32'h2004);
    chk("ld_c1_ready", 32'(d_ready), 32'h0);
    chk("ld_c1_we", 32'(bus_we), 32'h0);
    tick();
    chk("ld_c2_ready", 32'(d_ready), 32'h0);
    chk("ld_c2_we", 32'(bus_we), 32'h0);
    tick();
    chk("ld_c3_ready", 32'(d_ready), 32'h1);
    chk("ld_c3_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_c3_fault", 32'(d_fault), 32'h0);
    chk("ld_c3_i_ready", 32'(i_ready), 32'h0);
    chk("ld_c3_we", 32'(bus_we), 32'h0);
    d_req = 1'b0;
    tick();
    chk("ld_done_busy", 32'(busy), 32'h0);

    // Store to RAM: one bus_we cycle, ready one cycle later
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2010; d_wdata = 32'h12345678;
    bus_rdata = 32'h99999999;
    tick();
    chk("st_c1_we", 32'(bus_we), 32'h0);
    chk("st_c1_ready", 32'(d_ready), 32'h0);
    tick();
    chk("st_c2_we", 32'(bus_we), 32'h1);
    chk("st_c2_bus_addr", bus_addr, 32'h2010);
    chk("st_c2_bus_wdata", bus_wdata, 32'h12345678);
    chk("st_c2_ready", 32'(d_ready), 32'h0);
    tick();
    chk("st_c3_we", 32'(bus_we), 32'h0);
    chk("st_c3_ready", 32'(d_ready), 32'h1);
    chk("st_c3_fault", 32'(d_fault), 32'h0);
    chk("st_c3_rdata_kept", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Fetch from ROM: ROM_WAIT+2 = 4 cycles
    i_req = 1'b1; i_addr = 32'h0040; bus_rdata = 32'h0BADC0DE;
    tick();
    chk("fe_c1_ready", 32'(i_ready), 32'h0);
    chk("fe_c1_bus_addr", bus_addr, 32'h0040);
    tick();
    chk("fe_c2_ready", 32'(i_ready), 32'h0);
    tick();
    chk("fe_c3_ready", 32'(i_ready), 32'h0);
    tick();
    chk("fe_c4_ready", 32'(i_ready), 32'h1);
    chk("fe_c4_rdata", i_rdata, 32'h0BADC0DE);
    chk("fe_c4_fault", 32'(i_fault), 32'h0);
    chk("fe_c4_d_rdata_kept", d_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();

    // Illegal: store to ROM
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100; d_wdata = 32'hFFFF0000;
    tick();
    chk("rom_st_ready", 32'(d_ready), 32'h1);
    chk("rom_st_fault", 32'(d_fault), 32'h1);
    chk("rom_st_rdata", d_rdata, 32'h0);
    chk("rom_st_we", 32'(bus_we), 32'h0);
    chk("rom_st_bus_addr", bus_addr, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("rom_st_we_after", 32'(bus_we), 32'h0);

    // Illegal: fetch from unmapped 0x3000
    i_req = 1'b1; i_addr = 32'h3000;
    tick();
    chk("unm_fe_ready", 32'(i_ready), 32'h1);
    chk("unm_fe_fault", 32'(i_fault), 32'h1);
    chk("unm_fe_rdata", i_rdata, 32'h0);
    chk("unm_fe_we", 32'(bus_we), 32'h0);
    i_req = 1'b0;
    tick();

    // Contention: both ports requesting continuously
    i_req = 1'b1; i_addr = 32'h0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; bus_rdata = 32'h55AA55AA;
`ifdef MEM_ARB_RR_EN
    exp_seq[0] = 32'd1; exp_seq[1] = 32'd2; exp_seq[2] = 32'd1; exp_seq[3] = 32'd2;
`else
    exp_seq[0] = 32'd1; exp_seq[1] = 32'd1; exp_seq[2] = 32'd1; exp_seq[3] = 32'd1;
`endif
    grants = 0;
    for (int c = 0; c < 80 && grants < 4; c++) begin
      tick();
      chk("contend_overlap", 32'(d_ready & i_ready), 32'h0);
      if (d_ready || i_ready) begin
        got[grants] = d_ready ? 32'd1 : 32'd2;
        if (d_ready) chk("contend_d_rdata", d_rdata, 32'h55AA55AA);
        else         chk("contend_i_rdata", i_rdata, 32'h55AA55AA);
        grants++;
        if (grants == 4) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("contend_grant_count", 32'(grants), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < grants) chk("contend_order", got[g], exp_seq[g]);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    chk("contend_done_busy", 32'(busy), 32'h0);

    // Reset during ACCESS of a store with cnt>0
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2010; d_wdata = 32'hA5A5A5A5;
    tick();
    chk("rst_mid_busy", 32'(busy), 32'h1);
    chk("rst_mid_we", 32'(bus_we), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    d_req = 1'b0; d_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_hold_we", 32'(bus_we), 32'h0);
      chk("rst_hold_ready", 32'(d_ready), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    chk("rst_rel_we", 32'(bus_we), 32'h0);
    chk("rst_rel_ready", 32'(d_ready), 32'h0);

    // Fresh load after reset completes normally
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; bus_rdata = 32'hCAFEF00D;
    tick();
    chk("post_rst_c1_bus_addr", bus_addr, 32'h2000);
    tick();
    chk("post_rst_c2_ready", 32'(d_ready), 32'h0);
    tick();
    chk("post_rst_c3_ready", 32'(d_ready), 32'h1);
    chk("post_rst_c3_rdata", d_rdata, 32'hCAFEF00D);
    chk("post_rst_c3_fault", 32'(d_fault), 32'h0);
    d_req = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
